i2s_audio_tx: RTL and testbench

Serialises the 9-bit excess-256 left/right mix produced by the panner/mixer stage into a standard Philips I2S stream (BCLK, LRCLK, SDATA) for an external audio codec. It runs alongside the on-chip delta-sigma DAC outputs and consumes the same `left`/`right` buses. The block latches a coherent stereo pair once per frame, converts it to 16-bit two's complement, and shifts it out MSB-first.

---
 rtl/i2s_audio_tx.sv | 115 +++++++++++
 tb/tb_i2s_audio_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: latches the 9-bit excess-256 stereo mix once per frame and shifts it out as Philips I2S.
// Define I2S_AVERAGE_EN to replace point sampling with a frame-length boxcar average of each channel.
module i2s_audio_tx #(
  parameter int BCLK_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] left,
  input  logic [8:0] right,
  input  logic       mute,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata,
  output logic       sample_strobe
);

  localparam int DATA_W = 9;
  localparam int WORD_W = 16;
  localparam int DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0]         div_cnt;
  logic [5:0]               slot;
  logic [5:0]               slot_next;
  logic                     bclk_fall;
  logic                     latch;
  logic [DATA_W-1:0]        left_src;
  logic [DATA_W-1:0]        right_src;
  logic signed [WORD_W-1:0] left_word_p1;
  logic signed [WORD_W-1:0] right_word_p1;

  function automatic logic signed [WORD_W-1:0] to_pcm(input logic [DATA_W-1:0] x);
    return {~x[8], x[7:0], 7'b0};
  endfunction

  // Slot 1..16 carries the left word MSB-first, 33..48 the right word; 15-off == ~off for 4 bits.
  function automatic logic frame_bit(input logic [5:0] s,
                                     input logic [WORD_W-1:0] lw,
                                     input logic [WORD_W-1:0] rw);
    logic [5:0] off_l;
    logic [5:0] off_r;
    off_l = s - 6'd1;
    off_r = s - 6'd33;
    if (s >= 6'd1 && s <= 6'd16) return lw[~off_l[3:0]];
    if (s >= 6'd33 && s <= 6'd48) return rw[~off_r[3:0]];
    return 1'b0;
  endfunction

  assign bclk_fall = (div_cnt == DIV_LAST) && i2s_bclk;
  assign slot_next = slot + 6'd1;
  assign latch     = bclk_fall && (slot == 6'd63);

`ifdef I2S_AVERAGE_EN
  localparam int LOG_H = $clog2(BCLK_HALF);
  localparam int ACC_W = WORD_W + LOG_H;

  logic [ACC_W-1:0] acc_l_p0;
  logic [ACC_W-1:0] acc_r_p0;

  // Stage p0: frame-long sums; the latch-cycle sample starts the next window.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_l_p0 <= '0;
      acc_r_p0 <= '0;
    end else if (latch) begin
      acc_l_p0 <= ACC_W'(left);
      acc_r_p0 <= ACC_W'(right);
    end else begin
      acc_l_p0 <= acc_l_p0 + ACC_W'(left);
      acc_r_p0 <= acc_r_p0 + ACC_W'(right);
    end
  end

  assign left_src  = acc_l_p0[7+LOG_H +: DATA_W];
  assign right_src = acc_r_p0[7+LOG_H +: DATA_W];
`else
  assign left_src  = left;
  assign right_src = right;
`endif

  // Stage p1: bit clock, slot counter, holding words and serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt       <= '0;
      slot          <= '0;
      i2s_bclk      <= 1'b0;
      i2s_lrclk     <= 1'b0;
      i2s_sdata     <= 1'b0;
      sample_strobe <= 1'b0;
      left_word_p1  <= '0;
      right_word_p1 <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      sample_strobe <= latch;

      if (bclk_fall) begin
        slot      <= slot_next;
        i2s_lrclk <= slot_next[5];
        i2s_sdata <= frame_bit(slot_next, left_word_p1, right_word_p1);
      end

      if (latch) begin
        left_word_p1  <= mute ? '0 : to_pcm(left_src);
        right_word_p1 <= mute ? '0 : to_pcm(right_src);
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: rebuilds each I2S frame from the pins as a codec would and compares it
// with words predicted from the input history (point sample or frame average when I2S_AVERAGE_EN is set).
module tb_i2s_audio_tx;

  localparam int H  = 4;
  localparam int SH = 7 + $clog2(H);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] left = 9'h100;
  logic [8:0] right = 9'h100;
  logic       mute = 1'b0;
  logic       i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe;

  int total = 0;
  int bad = 0;

  i2s_audio_tx #(.BCLK_HALF(H)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .mute(mute),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  // Excess-256 to 16-bit PCM: (x - 256) * 128, kept to 16 bits.
  function automatic logic [15:0] pcm(input int x);
    int v;
    v = (x - 256) * 128;
    return v[15:0];
  endfunction

  function automatic logic [63:0] frame_model(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 16'h0000, r, 15'h0000};
  endfunction

  localparam logic [63:0] LR_MODEL = {32'h0000_0000, 32'hFFFF_FFFF};

  // Reference model and frame capture. Inputs change at negedge+1, so at negedge they are the
  // values the DUT sampled on the edge just passed.
  int          sum_l = 0, sum_r = 0;
  int          slot = -1;
  int          frame_cnt = 0;
  logic        bclk_prev = 1'b0;
  logic [15:0] exp_l = 16'h0, exp_r = 16'h0;
  logic [15:0] cap_exp_l = 16'h0, cap_exp_r = 16'h0;
  logic [63:0] bits_acc = '0, lr_acc = '0, cap_data = '0, cap_lr = '0;

  always @(negedge clk) begin
    if (reset) begin
      sum_l = 0;
      sum_r = 0;
      slot  = -1;
    end else if (sample_strobe) begin
`ifdef I2S_AVERAGE_EN
      exp_l = mute ? 16'h0 : pcm((sum_l >> SH) % 512);
      exp_r = mute ? 16'h0 : pcm((sum_r >> SH) % 512);
`else
      exp_l = mute ? 16'h0 : pcm(int'(left));
      exp_r = mute ? 16'h0 : pcm(int'(right));
`endif
      sum_l = int'(left);
      sum_r = int'(right);
      slot  = 0;
    end else begin
      sum_l += int'(left);
      sum_r += int'(right);
      if (i2s_bclk && !bclk_prev && slot >= 0 && slot < 64) begin
        bits_acc[63-slot] = i2s_sdata;
        lr_acc[63-slot]   = i2s_lrclk;
        slot++;
        if (slot == 64) begin
          cap_data  = bits_acc;
          cap_lr    = lr_acc;
          cap_exp_l = exp_l;
          cap_exp_r = exp_r;
          frame_cnt++;
        end
      end
    end
    bclk_prev = i2s_bclk;
  end

  task automatic wait_frame(input int n);
    int start, cyc;
    start = frame_cnt;
    cyc = 0;
    while (frame_cnt < start + n && cyc < (n + 1) * 160 * H) begin
      @(posedge clk);
      cyc++;
    end
    if (frame_cnt < start + n) begin
      total++;
      bad++;
      $display("FAIL frame_timeout got=%0d frames want=%0d", frame_cnt - start, n);
    end
  endtask

  task automatic wait_slot(input int s);
    int cyc;
    cyc = 0;
    while (slot != s && cyc < 300 * H) begin
      @(posedge clk);
      cyc++;
    end
    if (slot != s) begin
      total++;
      bad++;
      $display("FAIL slot_timeout got=%0d want=%0d", slot, s);
    end
  endtask

  task automatic test_reset;
    int rise_at, fall_at, strobe_at, strobe_w, sdata_ones;
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_outputs got=%b want=0000",
                 {i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe});
      end
    end
    #1 reset = 1'b0;
    rise_at = -1; fall_at = -1; strobe_at = -1; strobe_w = 0; sdata_ones = 0;
    for (int n = 1; n <= 128 * H + 4; n++) begin
      @(negedge clk);
      if (i2s_bclk && rise_at < 0) rise_at = n;
      if (!i2s_bclk && rise_at >= 0 && fall_at < 0) fall_at = n;
      if (sample_strobe && strobe_at < 0) strobe_at = n;
      if (sample_strobe) strobe_w++;
      if (strobe_at < 0 && i2s_sdata) sdata_ones++;
    end
    total++;
    if (rise_at !== H) begin
      bad++; $display("FAIL first_rise got=%0d want=%0d", rise_at, H);
    end
    total++;
    if (fall_at !== 2 * H) begin
      bad++; $display("FAIL first_fall got=%0d want=%0d", fall_at, 2 * H);
    end
    total++;
    if (strobe_at !== 128 * H) begin
      bad++; $display("FAIL first_strobe got=%0d want=%0d", strobe_at, 128 * H);
    end
    total++;
    if (strobe_w !== 1) begin
      bad++; $display("FAIL strobe_width got=%0d want=1", strobe_w);
    end
    total++;
    if (sdata_ones !== 0) begin
      bad++; $display("FAIL first_frame_zero got=%0d ones want=0", sdata_ones);
    end
  endtask

  task automatic test_full_scale;
    @(negedge clk); #1;
    left = 9'h1FF; right = 9'h000; mute = 1'b0;
    wait_frame(3);
    total++;
    if (cap_data !== frame_model(16'h7F80, 16'h8000)) begin
      bad++; $display("FAIL full_scale_data got=%h want=%h", cap_data, frame_model(16'h7F80, 16'h8000));
    end
    total++;
    if (cap_lr !== LR_MODEL) begin
      bad++; $display("FAIL full_scale_lrclk got=%h want=%h", cap_lr, LR_MODEL);
    end
  endtask

  task automatic test_silence;
    @(negedge clk); #1;
    left = 9'h100; right = 9'h100;
    wait_frame(3);
    total++;
    if (cap_data !== 64'h0) begin
      bad++; $display("FAIL silence_data got=%h want=0", cap_data);
    end
  endtask

  task automatic test_mute;
    @(negedge clk); #1;
    left = 9'h1FF; right = 9'h1FF; mute = 1'b1;
    wait_frame(3);
    total++;
    if (cap_data !== 64'h0) begin
      bad++; $display("FAIL mute_data got=%h want=0", cap_data);
    end
    @(negedge clk); #1;
    mute = 1'b0;
    wait_frame(2);
    total++;
    if (cap_data !== frame_model(16'h7F80, 16'h7F80)) begin
      bad++; $display("FAIL unmute_data got=%h want=%h", cap_data, frame_model(16'h7F80, 16'h7F80));
    end
  endtask

  task automatic test_mid_frame;
    @(negedge clk); #1;
    left = 9'h1FF; right = 9'h000;
    wait_frame(3);
    wait_slot(8);
    @(negedge clk); #1;
    left = 9'h000;
    wait_frame(1);
    total++;
    if (cap_data !== frame_model(16'h7F80, 16'h8000)) begin
      bad++; $display("FAIL mid_frame_current got=%h want=%h", cap_data, frame_model(16'h7F80, 16'h8000));
    end
    wait_frame(1);
    total++;
    if (cap_data !== frame_model(cap_exp_l, cap_exp_r)) begin
      bad++; $display("FAIL mid_frame_next got=%h want=%h", cap_data, frame_model(cap_exp_l, cap_exp_r));
    end
`ifndef I2S_AVERAGE_EN
    total++;
    if (cap_exp_l !== 16'h8000) begin
      bad++; $display("FAIL mid_frame_next_word got=%h want=8000", cap_exp_l);
    end
`endif
  endtask

  bit alt_on;

  task automatic test_averaging;
    right = 9'h100;
    alt_on = 1'b1;
    fork
      while (alt_on) begin
        @(negedge clk); #1;
        left = (left == 9'h000) ? 9'h1FF : 9'h000;
      end
      begin
        wait_frame(3);
        alt_on = 1'b0;
      end
    join
    total++;
    if (cap_data !== frame_model(cap_exp_l, 16'h0000)) begin
      bad++; $display("FAIL avg_data got=%h want=%h", cap_data, frame_model(cap_exp_l, 16'h0000));
    end
    total++;
`ifdef I2S_AVERAGE_EN
    if (cap_exp_l !== 16'hFF80) begin
      bad++; $display("FAIL avg_word got=%h want=ff80", cap_exp_l);
    end
`else
    if (cap_exp_l !== 16'h8000 && cap_exp_l !== 16'h7F80) begin
      bad++; $display("FAIL point_word got=%h want=8000 or 7f80", cap_exp_l);
    end
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      left  = 9'($urandom_range(0, 511));
      right = 9'($urandom_range(0, 511));
      mute  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 300)) @(negedge clk);
      #1 left = 9'($urandom_range(0, 511));
      wait_frame(1);
      total++;
      if (cap_data !== frame_model(cap_exp_l, cap_exp_r)) begin
        bad++; $display("FAIL random_frame_%0d got=%h want=%h", i, cap_data, frame_model(cap_exp_l, cap_exp_r));
      end
      total++;
      if (cap_lr !== LR_MODEL) begin
        bad++; $display("FAIL random_lrclk_%0d got=%h want=%h", i, cap_lr, LR_MODEL);
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int rise_at, fall_at;
    @(negedge clk); #1;
    left = 9'h1FF; right = 9'h000;
    wait_frame(1);
    wait_slot(40);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe} !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_outputs got=%b want=0000",
                      {i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe});
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    rise_at = -1; fall_at = -1;
    for (int n = 1; n <= 4 * H; n++) begin
      @(negedge clk);
      if (i2s_bclk && rise_at < 0) rise_at = n;
      if (!i2s_bclk && rise_at >= 0 && fall_at < 0) fall_at = n;
    end
    total++;
    if (rise_at !== H || fall_at !== 2 * H) begin
      bad++; $display("FAIL reset_mid_restart got=%0d/%0d want=%0d/%0d", rise_at, fall_at, H, 2 * H);
    end
    wait_frame(2);
    total++;
    if (cap_data !== frame_model(cap_exp_l, cap_exp_r)) begin
      bad++; $display("FAIL reset_mid_resume got=%h want=%h", cap_data, frame_model(cap_exp_l, cap_exp_r));
    end
  endtask

  initial begin
    test_reset;
    test_full_scale;
    test_silence;
    test_mute;
    test_mid_frame;
    test_averaging;
    test_random;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
